// File: rtl/vip_pkg.sv
// Shared video-pipeline constants and helpers for the 3x3 window generator and median filter.
// SYNC_LAT is the sync-to-window latency that downstream timing checks rely on.
package vip_pkg;

  localparam int VIP_DATA_W    = 8;
  localparam int VIP_IMG_WIDTH = 640;
  localparam int SYNC_LAT      = 2;

  // Row index within the frame, saturating once two full lines are buffered.
  typedef logic [1:0] row_t;
  localparam row_t ROW_FIRST = 2'd0;
  localparam row_t ROW_FULL  = 2'd2;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer: one write port, one synchronous read port.
// A read and write to the same address in one cycle return the old content.
module line_buf_sdp
  import vip_pkg::*;
#(
  parameter int DEPTH  = VIP_IMG_WIDTH,
  parameter int DATA_W = VIP_DATA_W,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_gen_3x3.sv
// 3x3 sliding window generator over a raster grey stream, feeding median_3x3.
// Row 1 of the window is the oldest line, column 3 the newest pixel; 2-clk latency.
module matrix_gen_3x3
  import vip_pkg::*;
#(
  parameter int IMG_WIDTH = VIP_IMG_WIDTH,
  parameter int DATA_W    = VIP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic [DATA_W-1:0] data11,
  output logic [DATA_W-1:0] data12,
  output logic [DATA_W-1:0] data13,
  output logic [DATA_W-1:0] data21,
  output logic [DATA_W-1:0] data22,
  output logic [DATA_W-1:0] data23,
  output logic [DATA_W-1:0] data31,
  output logic [DATA_W-1:0] data32,
  output logic [DATA_W-1:0] data33
);

  localparam int ADDR_W = addr_w(IMG_WIDTH);
  localparam int CNT_W  = $clog2(IMG_WIDTH + 1);
  localparam logic [CNT_W-1:0] COL_END = CNT_W'(IMG_WIDTH);

  function automatic logic [CNT_W-1:0] col_inc(input logic [CNT_W-1:0] c);
    return (c < COL_END) ? c + 1'b1 : c;
  endfunction

  function automatic row_t row_inc(input row_t r);
    return (r == ROW_FULL) ? r : r + 2'd1;
  endfunction

  logic [CNT_W-1:0]  col_cnt;
  row_t              row_cnt;
  logic              frame_ok;
  logic              vsync_prev;

  logic              vld_p0, vsync_rise, href_fall, col_ok_p0;
  row_t              row_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vsync_p1, href_p1, clken_p1, vld_p1;
  logic              col_ok_p1, first_p1;
  row_t              row_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] pix_p1;
  logic [DATA_W-1:0] lb0_q, lb1_q, top_p1, mid_p1;

  logic              vsync_p2, href_p2, clken_p2;
  logic [DATA_W-1:0] win_p2 [3][3];

  assign vld_p0     = per_frame_clken & per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_prev;
  assign href_fall  = href_p1 & ~per_frame_href;
  assign col_ok_p0  = col_cnt < COL_END;
  assign addr_p0    = col_cnt[ADDR_W-1:0];
  // A pixel arriving with the vsync rise, or any pixel after a mid-frame reset, is row 0.
  assign row_p0     = (vsync_rise || !frame_ok) ? ROW_FIRST : row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= ROW_FIRST;
      frame_ok   <= 1'b0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= per_frame_vsync;
      if (!per_frame_href)      col_cnt <= '0;
      else if (per_frame_clken) col_cnt <= col_inc(col_cnt);
      if (vsync_rise) begin
        row_cnt  <= ROW_FIRST;
        frame_ok <= 1'b1;
      end else if (href_fall) begin
        row_cnt  <= row_inc(row_cnt);
      end
    end
  end

  // Stage 1: line-buffer read/write, register the incoming pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1  <= 1'b0;
      href_p1   <= 1'b0;
      clken_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      pix_p1    <= '0;
      row_p1    <= ROW_FIRST;
      col_ok_p1 <= 1'b0;
      first_p1  <= 1'b0;
      addr_p1   <= '0;
    end else begin
      vsync_p1 <= per_frame_vsync;
      href_p1  <= per_frame_href;
      clken_p1 <= per_frame_clken;
      vld_p1   <= vld_p0;
      if (vld_p0) begin
        pix_p1    <= per_img_y;
        row_p1    <= row_p0;
        col_ok_p1 <= col_ok_p0;
        first_p1  <= (col_cnt == '0);
        addr_p1   <= addr_p0;
      end
    end
  end

  line_buf_sdp #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lb0 (
    .clk   (clk),
    .we    (vld_p0 & col_ok_p0),
    .waddr (addr_p0),
    .wdata (per_img_y),
    .re    (vld_p0),
    .raddr (addr_p0),
    .rdata (lb0_q)
  );

  // LB1 takes LB0's old word one cycle late; that address is not read again for a full line.
  line_buf_sdp #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lb1 (
    .clk   (clk),
    .we    (vld_p1 & col_ok_p1),
    .waddr (addr_p1),
    .wdata (lb0_q),
    .re    (vld_p0),
    .raddr (addr_p0),
    .rdata (lb1_q)
  );

  assign top_p1 = (row_p1 == ROW_FULL && col_ok_p1)  ? lb1_q : '0;
  assign mid_p1 = (row_p1 != ROW_FIRST && col_ok_p1) ? lb0_q : '0;

  // Stage 2: shift the window and load the new column; delayed syncs line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p2 <= 1'b0;
      href_p2  <= 1'b0;
      clken_p2 <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p2[r][c] <= '0;
    end else begin
      vsync_p2 <= vsync_p1;
      href_p2  <= href_p1;
      clken_p2 <= clken_p1;
      if (vld_p1) begin
        for (int r = 0; r < 3; r++) begin
          win_p2[r][0] <= first_p1 ? '0 : win_p2[r][1];
          win_p2[r][1] <= first_p1 ? '0 : win_p2[r][2];
        end
        win_p2[0][2] <= top_p1;
        win_p2[1][2] <= mid_p1;
        win_p2[2][2] <= pix_p1;
      end else if (!href_p1) begin
        for (int r = 0; r < 3; r++) begin
          win_p2[r][0] <= '0;
          win_p2[r][1] <= '0;
        end
      end
    end
  end

  assign matrix_frame_vsync = vsync_p2;
  assign matrix_frame_href  = href_p2;
  assign matrix_frame_clken = clken_p2;

  assign data11 = win_p2[0][0];
  assign data12 = win_p2[0][1];
  assign data13 = win_p2[0][2];
  assign data21 = win_p2[1][0];
  assign data22 = win_p2[1][1];
  assign data23 = win_p2[1][2];
  assign data31 = win_p2[2][0];
  assign data32 = win_p2[2][1];
  assign data33 = win_p2[2][2];

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Scoreboard bench for matrix_gen_3x3 with a 4-pixel line buffer.
// Stimulus pushes expected windows; a negedge monitor pops and compares them.
module tb_matrix_gen_3x3;

  localparam int W  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, vsync, href, clken;
  logic [DW-1:0] y;
  logic          m_vs, m_hr, m_ce;
  logic [DW-1:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
  logic [71:0]   win;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  logic [71:0] sb [$];
  logic [71:0] exp_w;
  logic [2:0]  hist1, hist2;

  typedef struct {
    int          tag;
    int          r;
    int          c;
    logic [71:0] w;
  } vec_t;
  vec_t vecs [$];

  matrix_gen_3x3 #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (vsync),
    .per_frame_href     (href),
    .per_frame_clken    (clken),
    .per_img_y          (y),
    .matrix_frame_vsync (m_vs),
    .matrix_frame_href  (m_hr),
    .matrix_frame_clken (m_ce),
    .data11             (d11),
    .data12             (d12),
    .data13             (d13),
    .data21             (d21),
    .data22             (d22),
    .data23             (d23),
    .data31             (d31),
    .data32             (d32),
    .data33             (d33)
  );

  assign win = {d11, d12, d13, d21, d22, d23, d31, d32, d33};

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * 16 + c);
  endfunction

  // Reference window: rows r-2..r, columns c-2..c; top rows vanish past the buffer width.
  function automatic logic [71:0] model(input int r, input int c, input bit mask);
    logic [71:0] w;
    logic [DW-1:0] v;
    int rr, cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r - 2 + i;
        cc = c - 2 + j;
        v  = '0;
        if (rr >= 0 && cc >= 0) begin
          if (rr == r) v = pix(rr, cc);
          else if (!mask && cc < W) v = pix(rr, cc);
        end
        w[(8 - (i * 3 + j)) * 8 +: 8] = v;
      end
    end
    return w;
  endfunction

  task automatic push_exp(input int tag, input int r, input int c, input bit mask);
    logic [71:0] w;
    w = model(r, c, mask);
    foreach (vecs[i])
      if (vecs[i].tag == tag && vecs[i].r == r && vecs[i].c == c) w = vecs[i].w;
    sb.push_back(w);
  endtask

  task automatic drive(input bit vs, input bit hr, input bit ce, input logic [DW-1:0] px);
    vsync = vs;
    href  = hr;
    clken = ce;
    y     = px;
    @(posedge clk);
    #1;
  endtask

  task automatic run_lines(input int tag, input int r0, input int rows, input int cols,
                           input bit gaps, input bit mask);
    for (int r = r0; r < r0 + rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        push_exp(tag, r, c, mask);
        drive(1'b1, 1'b1, 1'b1, pix(r, c));
        if (gaps) drive(1'b1, 1'b1, 1'b0, 8'hEE);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic run_frame(input int tag, input int rows, input int cols, input bit gaps);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    run_lines(tag, 0, rows, cols, gaps, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Sync outputs must equal the inputs two edges earlier; reset empties the history.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= '0;
      hist2 <= '0;
    end else begin
      hist1 <= {vsync, href, clken};
      hist2 <= hist1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      n_tests++;
      if ({win, m_vs, m_hr, m_ce} !== '0) begin
        n_fail++;
        $display("FAIL reset_clear: got win=%h syncs=%b%b%b, expected all zero", win, m_vs, m_hr, m_ce);
      end
    end else begin
      n_tests++;
      if ({m_vs, m_hr, m_ce} !== hist2) begin
        n_fail++;
        $display("FAIL sync_delay: got %b%b%b, expected %b", m_vs, m_hr, m_ce, hist2);
      end
      if (m_ce) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL window_extra: got %h, expected no window", win);
        end else begin
          exp_w = sb.pop_front();
          if (win !== exp_w) begin
            n_fail++;
            $display("FAIL window: got %h, expected %h", win, exp_w);
          end
        end
      end
    end
    if (done) begin
      n_tests++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d windows pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    vecs.push_back('{0, 0, 1, 72'h000000_000000_000001});
    vecs.push_back('{0, 1, 0, 72'h000000_000000_000010});
    vecs.push_back('{0, 1, 3, 72'h000000_010203_111213});
    vecs.push_back('{0, 2, 2, 72'h000102_101112_202122});
    vecs.push_back('{1, 1, 4, 72'h000000_020300_121314});
    vecs.push_back('{1, 1, 5, 72'h000000_030000_131415});
    vecs.push_back('{1, 2, 0, 72'h000000_000010_000020});
    vecs.push_back('{1, 2, 3, 72'h010203_111213_212223});

    rst_n = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    clken = 1'b0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous 4x4 frame, then the same frame with clken toggling.
    run_frame(0, 4, W, 1'b0);
    run_frame(0, 4, W, 1'b1);

    // Reset mid-row 2; the rest of the frame stays masked until the next vsync rise.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    run_lines(0, 0, 2, W, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      push_exp(0, 2, c, 1'b0);
      drive(1'b1, 1'b1, 1'b1, pix(2, c));
    end
    repeat (3) drive(1'b1, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    run_lines(2, 3, 1, W, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    run_frame(0, 4, W, 1'b0);

    // Lines wider than the line buffer.
    run_frame(1, 3, 6, 1'b0);

    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
    done = 1'b1;
  end

endmodule
